// File: rtl/stc0_fft_sequencer.sv
// Radix-2 DIT FFT butterfly scheduler: walks every stage, issues one descriptor per beat, throttled by retirements.
// Build option STC0_SEQ_DRAIN_EN: when defined, all in-flight butterflies drain between stages.
module stc0_fft_sequencer #(
  parameter int NUM_POINTS_LOG2 = 10,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       start_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [NUM_POINTS_LOG2-1:0] addr_a_o,
  output logic [NUM_POINTS_LOG2-1:0] addr_b_o,
  output logic [NUM_POINTS_LOG2-2:0] tw_idx_o,
  output logic [3:0]                 stage_o,
  input  logic                       retire_i,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int AW = NUM_POINTS_LOG2;
  localparam int KW = NUM_POINTS_LOG2 - 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [3:0]    LAST_STAGE = 4'(NUM_POINTS_LOG2 - 1);
  localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
  localparam logic [OW-1:0] MAX_OUT    = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [OW-1:0] out_q, out_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic [KW-1:0] tw_q, tw_d;
  logic [3:0]    stage_q;
  logic [AW-1:0] kx, half, pos, grp;
  logic          fire;

  assign fire = valid_q & issue_ready_i;

  // Retire at zero is a protocol error and is dropped (saturation).
  always_comb begin
    out_d = out_q;
    if (fire && !retire_i) begin
      out_d = out_q + OW'(1);
    end else if (!fire && retire_i && (out_q != '0)) begin
      out_d = out_q - OW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ISSUE;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (fire) begin
          if (k_q != K_LAST) begin
            k_d = k_q + KW'(1);
          end else begin
            k_d = '0;
`ifdef STC0_SEQ_DRAIN_EN
            state_d = DRAIN;
`else
            if (s_q != LAST_STAGE) begin
              s_d = s_q + 4'd1;
            end else begin
              state_d = DRAIN;
            end
`endif
          end
        end
      end
      DRAIN: begin
        if (out_d == '0) begin
          if (s_q == LAST_STAGE) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Descriptor for the beat presented next cycle; widths truncate by construction.
  always_comb begin
    kx       = AW'(k_d);
    half     = AW'(1) << s_d;
    pos      = kx & (half - AW'(1));
    grp      = kx >> s_d;
    addr_a_d = (grp << (s_d + 4'd1)) | pos;
    addr_b_d = addr_a_d + half;
    tw_d     = KW'(pos << (LAST_STAGE - s_d));
  end

  always_comb begin
    valid_d = (state_d == ISSUE) && (out_d < MAX_OUT);
    busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= IDLE;
      s_q      <= '0;
      k_q      <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      stage_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (state_d == ISSUE) begin
        addr_a_q <= addr_a_d;
        addr_b_q <= addr_b_d;
        tw_q     <= tw_d;
        stage_q  <= s_d;
      end
    end
  end

  assign issue_valid_o = valid_q;
  assign addr_a_o      = addr_a_q;
  assign addr_b_o      = addr_b_q;
  assign tw_idx_o      = tw_q;
  assign stage_o       = stage_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_stc0_fft_sequencer.sv
// Bench for stc0_fft_sequencer (N=8, 3 outstanding): per-cycle model compare plus directed scenarios.
module tb_stc0_fft_sequencer;
  localparam int L     = 3;
  localparam int NH    = 4;
  localparam int TOTAL = 12;
  localparam int MAXO  = 3;
`ifdef STC0_SEQ_DRAIN_EN
  localparam bit DRAIN_EN = 1'b1;
`else
  localparam bit DRAIN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst_ni, start_i, issue_ready_i, retire_i;
  logic issue_valid_o, busy_o, done_o;
  logic [L-1:0] addr_a_o, addr_b_o;
  logic [L-2:0] tw_idx_o;
  logic [3:0] stage_o;

  stc0_fft_sequencer #(.NUM_POINTS_LOG2(L), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .arst_ni(arst_ni), .start_i(start_i), .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i), .addr_a_o(addr_a_o), .addr_b_o(addr_b_o),
    .tw_idx_o(tw_idx_o), .stage_o(stage_o), .retire_i(retire_i), .busy_o(busy_o), .done_o(done_o));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference descriptor for the i-th butterfly of the whole transform
  function automatic int d_stage(input int i); return i / NH; endfunction
  function automatic int d_a(input int i);
    int s = i / NH, k = i % NH, half = 1 << (i / NH);
    return (k / half) * 2 * half + (k % half);
  endfunction
  function automatic int d_b(input int i); return d_a(i) + (1 << (i / NH)); endfunction
  function automatic int d_tw(input int i);
    int k = i % NH, half = 1 << (i / NH);
    return (k % half) * (NH / half);
  endfunction

  // Behavioural model: index of next butterfly, work in flight, and what must show next cycle
  int m_idx, m_out;
  bit m_running, m_valid, m_busy, m_done;
  always @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      m_idx = 0; m_out = 0; m_running = 0; m_valid = 0; m_busy = 0; m_done = 0;
    end else begin
      bit f, nv, nb, nd, need_drain;
      f = m_valid && issue_ready_i;
      if (f && !retire_i) m_out++;
      else if (!f && retire_i && m_out > 0) m_out--;
      nv = 0; nb = 0; nd = 0;
      if (m_running) begin
        if (f) m_idx++;
        need_drain = (m_idx > 0) && (m_idx % NH == 0) && (DRAIN_EN || m_idx == TOTAL);
        if (need_drain && m_out == 0 && m_idx == TOTAL) begin
          m_running = 0; nd = 1;
        end else begin
          nb = 1;
          nv = !(need_drain && m_out > 0) && (m_out < MAXO);
        end
      end else if (start_i && !m_done) begin
        m_running = 1; m_idx = 0; nb = 1; nv = (m_out < MAXO);
      end
      m_valid = nv; m_busy = nb; m_done = nd;
    end
  end

  int done_seen = 0;
  always @(negedge clk) begin
    if (arst_ni) begin
      chk("valid", int'(issue_valid_o), int'(m_valid));
      chk("busy", int'(busy_o), int'(m_busy));
      chk("done", int'(done_o), int'(m_done));
      if (m_valid) begin
        chk("addr_a", int'(addr_a_o), d_a(m_idx));
        chk("addr_b", int'(addr_b_o), d_b(m_idx));
        chk("tw_idx", int'(tw_idx_o), d_tw(m_idx));
        chk("stage", int'(stage_o), d_stage(m_idx));
      end
      if (done_o) done_seen++;
    end
  end

  // Stimulus: ready pattern, retire scheduling, fire log
  int cyc = 0, last_due = -1, held = 0, freeze_left = 0, lat_lo = 2, lat_hi = 2, d0 = 0;
  bit rand_ready = 0, hold = 0, start_req = 0;
  int due[$];
  int obs_a[$], obs_b[$], obs_tw[$], obs_st[$], obs_cyc[$];

  function automatic void sched(input int t);
    int tt = t;
    if (tt <= last_due) tt = last_due + 1;
    due.push_back(tt);
    last_due = tt;
  endfunction

  task automatic tick();
    bit rdy;
    if (freeze_left > 0) begin rdy = 0; freeze_left--; end
    else if (rand_ready) rdy = ($urandom_range(3, 0) != 0);
    else rdy = 1;
    issue_ready_i = rdy;
    start_i = start_req;
    start_req = 0;
    while (due.size() > 0 && due[0] < cyc) void'(due.pop_front());
    retire_i = 0;
    if (due.size() > 0 && due[0] == cyc) begin void'(due.pop_front()); retire_i = 1; end
    if (issue_valid_o && rdy) begin
      obs_a.push_back(int'(addr_a_o)); obs_b.push_back(int'(addr_b_o));
      obs_tw.push_back(int'(tw_idx_o)); obs_st.push_back(int'(stage_o));
      obs_cyc.push_back(cyc);
      if (hold) held++;
      else sched(cyc + int'($urandom_range(lat_hi, lat_lo)));
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_run();
    obs_a.delete(); obs_b.delete(); obs_tw.delete(); obs_st.delete(); obs_cyc.delete();
    start_req = 1;
    d0 = done_seen;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done_seen == d0 && n < budget) begin tick(); n++; end
    repeat (3) tick();
    chk({nm, "_done_once"}, done_seen - d0, 1);
    chk({nm, "_busy_after"}, int'(busy_o), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, int'(issue_valid_o), 0);
    chk({tag, "_addr_a"}, int'(addr_a_o), 0);
    chk({tag, "_addr_b"}, int'(addr_b_o), 0);
    chk({tag, "_tw"}, int'(tw_idx_o), 0);
    chk({tag, "_stage"}, int'(stage_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
  endtask

  initial begin
    int n, nf, sa, sb, st, ss;
    bit frz;
    arst_ni = 0; start_i = 0; issue_ready_i = 0; retire_i = 0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    arst_ni = 1;

    // Hand-computed descriptors pin the reference model
    chk("pin_s0k0_a", d_a(0), 0);  chk("pin_s0k0_b", d_b(0), 1);  chk("pin_s0k0_tw", d_tw(0), 0);
    chk("pin_s1k1_a", d_a(5), 1);  chk("pin_s1k1_b", d_b(5), 3);  chk("pin_s1k1_tw", d_tw(5), 2);
    chk("pin_s2k3_a", d_a(11), 3); chk("pin_s2k3_b", d_b(11), 7); chk("pin_s2k3_tw", d_tw(11), 3);

    // Full throughput, retire two cycles after each fire
    rand_ready = 0; lat_lo = 2; lat_hi = 2;
    start_run();
    wait_done("run1", 200);
    chk("run1_issues", obs_a.size(), TOTAL);
    if (obs_a.size() == TOTAL) begin
      chk("run1_s0k0_a", obs_a[0], 0);  chk("run1_s0k0_b", obs_b[0], 1);  chk("run1_s0k0_tw", obs_tw[0], 0);
      chk("run1_s1k1_a", obs_a[5], 1);  chk("run1_s1k1_b", obs_b[5], 3);  chk("run1_s1k1_tw", obs_tw[5], 2);
      chk("run1_s2k3_a", obs_a[11], 3); chk("run1_s2k3_b", obs_b[11], 7); chk("run1_s2k3_tw", obs_tw[11], 3);
      chk("run1_s0k3_a", obs_a[3], 6);  chk("run1_s0k3_b", obs_b[3], 7);
      chk("run1_s1k0_a", obs_a[4], 0);  chk("run1_s1k0_b", obs_b[4], 2);
      chk("run1_s1k0_tw", obs_tw[4], 0); chk("run1_s1k0_stage", obs_st[4], 1);
      chk("run1_stage_gap", obs_cyc[4] - obs_cyc[3], DRAIN_EN ? 3 : 1);
    end

    // Random ready and latency, with a five-cycle ready-low freeze mid stage 1
    rand_ready = 1; lat_lo = 1; lat_hi = 6;
    start_run();
    n = 0; frz = 0;
    while (done_seen == d0 && n < 800) begin
      if (!frz && obs_a.size() >= 6 && issue_valid_o) begin
        sa = int'(addr_a_o); sb = int'(addr_b_o); st = int'(tw_idx_o); ss = int'(stage_o);
        nf = obs_a.size();
        freeze_left = 5;
        repeat (5) tick();
        n += 5;
        chk("frz_addr_a", int'(addr_a_o), sa); chk("frz_addr_b", int'(addr_b_o), sb);
        chk("frz_tw", int'(tw_idx_o), st);     chk("frz_stage", int'(stage_o), ss);
        chk("frz_valid", int'(issue_valid_o), 1);
        chk("frz_no_fire", obs_a.size(), nf);
        frz = 1;
      end else begin
        tick(); n++;
      end
    end
    repeat (3) tick();
    chk("run2_froze", int'(frz), 1);
    chk("run2_done_once", done_seen - d0, 1);
    chk("run2_issues", obs_a.size(), TOTAL);

    // Retirements withheld: limit reached, then one retire buys exactly one issue
    rand_ready = 0; lat_lo = 1; lat_hi = 4; hold = 1; held = 0;
    start_run();
    repeat (12) tick();
    chk("hold_fires", obs_a.size(), MAXO);
    chk("hold_valid_low", int'(issue_valid_o), 0);
    sched(cyc); held--;
    repeat (8) tick();
    chk("hold_one_more", obs_a.size(), MAXO + 1);
    hold = 0;
    for (int i = 0; i < held; i++) sched(cyc + 1 + i);
    held = 0;
    wait_done("run3", 300);
    chk("run3_issues", obs_a.size(), TOTAL);

    // Reset in stage 1 with retirements still in flight, then a clean restart
    rand_ready = 0; lat_lo = 3; lat_hi = 3;
    start_run();
    n = 0;
    while (obs_a.size() < 5 && n < 100) begin tick(); n++; end
    chk("rst_reached_s1", int'(obs_a.size() >= 5), 1);
    #2 arst_ni = 0;
    #1 chk_reset("midrst");
    @(negedge clk);
    cyc++;
    start_i = 0; retire_i = 0; issue_ready_i = 0;
    arst_ni = 1;
    rand_ready = 1; lat_lo = 1; lat_hi = 3;
    start_run();
    wait_done("run4", 400);
    chk("run4_issues", obs_a.size(), TOTAL);
    if (obs_a.size() > 0) begin
      chk("run4_first_a", obs_a[0], 0); chk("run4_first_b", obs_b[0], 1);
      chk("run4_first_tw", obs_tw[0], 0); chk("run4_first_stage", obs_st[0], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/stc0_fft_sequencer.md
# stc0_fft_sequencer

Stage/butterfly scheduler for the stc0 radix-2 in-place FFT. On `Start`, walks all `NUM_POINTS_LOG2` decimation-in-time stages and issues one butterfly descriptor per beat: A/B data-memory addresses, twiddle index and stage number. It sits between the control path (`stc0Ctrl` command decode) and the butterfly datapath/twiddle SRAM. It throttles issue against butterfly retirements so in-flight work stays bounded and stage hazards are avoided.

## Interface
- `NUM_POINTS_LOG2`, 10: log2 of transform size N; the block issues N/2 butterflies per stage.
- `MAX_OUTSTANDING`, 8: maximum issued-but-not-retired butterflies; must be ≥1 and <2^NUM_POINTS_LOG2.
- `Clk` in 1: single clock for all logic.
- `ARst` in 1: asynchronous, active-low reset.
- `Start` in 1: one-cycle request to run a full transform; honoured only in IDLE.
- `IssueValid` out 1: descriptor outputs valid.
- `IssueReady` in 1: butterfly accepts the descriptor; fire = `IssueValid & IssueReady`.
- `AddrA` out NUM_POINTS_LOG2: upper-wing data address.
- `AddrB` out NUM_POINTS_LOG2: lower-wing data address.
- `TwIdx` out NUM_POINTS_LOG2-1: twiddle ROM/SRAM index.
- `Stage` out 4: current stage number, 0-based.
- `Retire` in 1: one butterfly result written back (single-cycle pulse per butterfly).
- `Busy` out 1: high from the cycle after an accepted `Start` until `Done`.
- `Done` out 1: one-cycle pulse at transform completion.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- Counters: stage `s` (4 b), butterfly `k` (NUM_POINTS_LOG2-1 b), `outstanding` (enough bits to hold MAX_OUTSTANDING).
- Address math, with `half = 1<<s`, `pos = k & (half-1)`, `grp = k >> s`:
  - `AddrA = (grp << (s+1)) | pos`
  - `AddrB = AddrA + half`
  - `TwIdx = pos << (NUM_POINTS_LOG2-1-s)`
  - All values are truncated to port width, with no overflow by construction.
- IDLE:
  - `Start` → ISSUE with s=0, k=0.
  - `Start` in any other state is ignored.
- ISSUE:
  - `IssueValid` is high when `outstanding < MAX_OUTSTANDING`, otherwise low (stall).
  - On fire with k≠N/2-1: k increments.
  - On fire with k=N/2-1: k←0, then go to DRAIN. With `STC0_SEQ_DRAIN_EN` undefined and s≠last stage, instead stay in ISSUE with s+1.
- DRAIN:
  - Waits until `outstanding==0`, evaluated on the post-update value, so a same-cycle final `Retire` counts.
  - Then: if s=last stage → DONE; else s+1 → ISSUE.
- DONE: asserts `Done` and returns to IDLE.
- `outstanding`:
  - +1 on fire, −1 on `Retire`; both in the same cycle leaves it unchanged.
  - `Retire` at 0 is a protocol error: saturate at 0.
- Descriptor outputs hold stable while `IssueValid & !IssueReady`.
- `IssueValid` never deasserts without a fire, except when `outstanding` reaches MAX_OUTSTANDING before the beat is presented. The limit is checked before presentation.

## Timing
- All outputs are registered.
- Reset values: `IssueValid`=0, `AddrA`=0, `AddrB`=0, `TwIdx`=0, `Stage`=0, `Busy`=0, `Done`=0, state=IDLE, counters=0.
- `Start` at cycle t → `Busy` and first `IssueValid` at t+1 (descriptor s0/k0).
- One descriptor per cycle at full throughput; the next descriptor is presented the cycle after a fire.
- DRAIN→ISSUE: next descriptor appears 1 cycle after `outstanding` reaches 0.
- `Done` is asserted 1 cycle after the final drain completes; `Busy` falls in the same cycle `Done` rises.
- Reset mid-operation:
  - Immediate return to IDLE and all counters clear.
  - In-flight `Retire` pulses arriving after reset are ignored, via saturation.

## Configuration
- `STC0_SEQ_DRAIN_EN`:
  - Defined: drain fully between every stage, which is safe for any butterfly latency.
  - Undefined: stages issue back-to-back; only the final drain before `Done` is kept. Intended for butterfly pipelines that guarantee write-before-read ordering.

## Test plan
- NUM_POINTS_LOG2=3, `IssueReady`=1, `Retire` 2 cycles after each fire, DRAIN_EN defined:
  - Expect 12 issues.
  - Stage0 k0: A0/B1/Tw0.
  - Stage1 k1: A1/B3/Tw2.
  - Stage2 k3: A3/B7/Tw3.
  - `Done` exactly once; `Busy` low afterwards.
- `IssueReady` held low 5 cycles mid-stage → outputs frozen, no k advance, `outstanding` unchanged.
- `Retire` withheld with MAX_OUTSTANDING=2 → exactly 2 fires then `IssueValid`=0; one `Retire` → exactly one more issue.
- Fire and `Retire` in the same cycle at `outstanding`=1 → `outstanding` stays 1. Final `Retire` in DRAIN → next descriptor/`Done` one cycle later.
- `ARst` asserted during stage 1 → all outputs at reset values within the same cycle. A new `Start` then begins again at s0/k0.
- DRAIN_EN undefined, N=8 → stage0 k3 (A6/B7) fire followed next cycle by stage1 k0 (A0/B2/Tw0) with no drain gap.
